// File: rtl/phy_rx_deframer_if.sv
// rtl/phy_rx_deframer_if.sv - PHY receive nibble bus and deframed byte/frame-end outputs
//
// Purpose: bundles the PHY receive pins and the deframer result signals.
// Signals:
//   phy_data_in[3:0]   receive nibble, low nibble of each byte first
//   phy_rx_dv          receive data valid
//   phy_rx_er          receive symbol error
//   r_data_out[7:0]    assembled byte
//   r_data_valid       one-cycle strobe per assembled byte
//   r_frame_end        one-cycle pulse at end of frame
//   r_ctrl_out[23:0]   {len, len}, valid with r_frame_end
//   r_err_flags[4:0]   odd nibble, runt, too long, rx_er seen, FCS error
//   r_frame_err        OR of r_err_flags, valid with r_frame_end
// Modports: master = PHY side (drives phy_*), slave = deframer (drives r_*).
interface phy_rx_deframer_if;
  logic [3:0]  phy_data_in;
  logic        phy_rx_dv;
  logic        phy_rx_er;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_frame_end;
  logic [23:0] r_ctrl_out;
  logic [4:0]  r_err_flags;
  logic        r_frame_err;

  modport master (
    output phy_data_in, phy_rx_dv, phy_rx_er,
    input  r_data_out, r_data_valid, r_frame_end, r_ctrl_out, r_err_flags, r_frame_err
  );

  modport slave (
    input  phy_data_in, phy_rx_dv, phy_rx_er,
    output r_data_out, r_data_valid, r_frame_end, r_ctrl_out, r_err_flags, r_frame_err
  );
endinterface

// File: rtl/phy_rx_deframer.sv
// rtl/phy_rx_deframer.sv - PHY receive deframer: preamble/SFD hunt, nibble-to-byte packing, frame-end report
//
// Purpose: samples the 4-bit PHY stream, locks on preamble (4'h5...) and SFD (4'hD),
// packs nibbles low-first into bytes, strobes each byte out, and reports length and
// error flags with a one-cycle frame-end pulse.
// Ports:
//   clk_phy  PHY clock (single domain)
//   reset    asynchronous active-low reset
//   bus      phy_rx_deframer_if.slave (PHY inputs, byte and frame-end outputs)
// Parameters: MIN_LEN (runt threshold, bytes), MAX_LEN (max forwarded bytes).
// Optional: define RX_CRC_CHECK_EN to check the CRC-32 FCS (err flag bit4);
// otherwise bit4 is tied 0.
module phy_rx_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input logic             clk_phy,
  input logic             reset,
  phy_rx_deframer_if.slave bus
);

  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state;
  logic        armed;     // set once rx_dv is seen low after reset
  logic        phase;     // 1 = low nibble held, waiting for high nibble
  logic [3:0]  low_nib;
  logic [11:0] len;
  logic        flag_long;
  logic        flag_er;

  logic [11:0] len_inc;
  logic        overflow;
  logic        crc_bad;
  logic [4:0]  end_flags;

  assign len_inc  = (len == 12'hFFF) ? len : len + 12'd1;
  // A saturated counter always means the frame is beyond any legal length.
  assign overflow = (len == 12'hFFF) || (len_inc > MAX_L);

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc;

  // Reflected CRC-32, one nibble per step, LSB first (matches low-nibble-first order).
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] x;
    x = c ^ {28'd0, d};
    for (int i = 0; i < 4; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++)
      y[i] = x[31-i];
    return y;
  endfunction

  // Residue over data+FCS, expressed in non-reflected bit order.
  assign crc_bad = (rev32(crc) != 32'hC704DD7B);
`else
  assign crc_bad = 1'b0;
`endif

  assign end_flags = {crc_bad, flag_er, flag_long, (len < MIN_L), phase};

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      armed            <= 1'b0;
      phase            <= 1'b0;
      low_nib          <= 4'd0;
      len              <= 12'd0;
      flag_long        <= 1'b0;
      flag_er          <= 1'b0;
      bus.r_data_out   <= 8'd0;
      bus.r_data_valid <= 1'b0;
      bus.r_frame_end  <= 1'b0;
      bus.r_ctrl_out   <= 24'd0;
      bus.r_err_flags  <= 5'd0;
      bus.r_frame_err  <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      crc              <= 32'hFFFFFFFF;
`endif
    end else begin
      bus.r_data_valid <= 1'b0;
      bus.r_frame_end  <= 1'b0;
      if (!bus.phy_rx_dv)
        armed <= 1'b1;

      case (state)
        IDLE: begin
          // Until armed, a live rx_dv is ignored so we never start mid-frame.
          if (armed && bus.phy_rx_dv)
            state <= (bus.phy_data_in == 4'h5) ? PRE : DROP;
        end

        PRE: begin
          if (!bus.phy_rx_dv) begin
            state <= IDLE;
          end else if (bus.phy_data_in == 4'hD) begin
            state     <= DATA;
            phase     <= 1'b0;
            len       <= 12'd0;
            flag_long <= 1'b0;
            flag_er   <= 1'b0;
`ifdef RX_CRC_CHECK_EN
            crc       <= 32'hFFFFFFFF;
`endif
          end else if (bus.phy_data_in != 4'h5) begin
            state <= DROP;
          end
        end

        DATA: begin
          if (bus.phy_rx_dv) begin
            if (bus.phy_rx_er)
              flag_er <= 1'b1;
`ifdef RX_CRC_CHECK_EN
            crc <= crc_nib(crc, bus.phy_data_in);
`endif
            if (!phase) begin
              low_nib <= bus.phy_data_in;
              phase   <= 1'b1;
            end else begin
              len   <= len_inc;
              phase <= 1'b0;
              if (overflow) begin
                flag_long <= 1'b1;
              end else begin
                bus.r_data_out   <= {bus.phy_data_in, low_nib};
                bus.r_data_valid <= 1'b1;
              end
            end
          end else begin
            // A dangling low nibble is reported via bit0 but never counted.
            bus.r_frame_end <= 1'b1;
            bus.r_ctrl_out  <= {len, len};
            bus.r_err_flags <= end_flags;
            bus.r_frame_err <= |end_flags;
            phase           <= 1'b0;
            state           <= IDLE;
          end
        end

        DROP: begin
          if (!bus.phy_rx_dv)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_rx_deframer.sv
// tb/tb_phy_rx_deframer.sv - directed table-driven bench for phy_rx_deframer
module tb_phy_rx_deframer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phy_rx_deframer_if bus ();

  phy_rx_deframer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_phy (clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [23:0] ctrl;
    logic [4:0]  flags;
    logic        err;
    int          nstrobes;
    int          dbad;
  } rec_t;

  typedef struct {
    int          nbytes;
    bit          extra;
    int          er_byte;
    int          exp_strobes;
    logic [23:0] exp_ctrl;
    logic [4:0]  exp_flags;
  } vec_t;

  int total = 0;
  int bad = 0;
  int total_strobes = 0;
  int coinc = 0;
  int idx = 0;
  int dbad = 0;
  logic [7:0] frame_buf [0:4199];
  rec_t recs [$];
  vec_t vecs [9];

  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0;
      dbad = 0;
    end else begin
      if (bus.r_data_valid) begin
        total_strobes++;
        if (bus.r_data_out !== frame_buf[idx]) dbad++;
        idx++;
      end
      if (bus.r_frame_end) begin
        if (bus.r_data_valid) coinc++;
        recs.push_back('{bus.r_ctrl_out, bus.r_err_flags, bus.r_frame_err, idx, dbad});
        idx = 0;
        dbad = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic dv, input logic er);
    bus.phy_data_in = d;
    bus.phy_rx_dv   = dv;
    bus.phy_rx_er   = er;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input bit extra, input int er_byte);
    for (int i = 0; i < 15; i++) drive(4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(frame_buf[i][3:0], 1'b1, i == er_byte);
      drive(frame_buf[i][7:4], 1'b1, i == er_byte);
    end
    if (extra) drive(4'hA, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
  endtask

  task automatic check_rec(input string name, input int exp_strobes,
                           input logic [23:0] exp_ctrl, input logic [4:0] exp_flags);
    rec_t r;
    for (int i = 0; i < 16; i++) begin
      if (recs.size() > 0) break;
      @(negedge clk);
    end
    if (recs.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no frame_end want frame_end", name);
    end else begin
      r = recs.pop_front();
      chk({name, "_strobes"}, r.nstrobes, exp_strobes);
      chk({name, "_data"}, r.dbad, 0);
      chk({name, "_ctrl"}, {8'd0, r.ctrl}, {8'd0, exp_ctrl});
      chk({name, "_flags"}, {27'd0, r.flags}, {27'd0, exp_flags});
      chk({name, "_ferr"}, {31'd0, r.err}, {31'd0, |exp_flags});
    end
  endtask

`ifdef RX_CRC_CHECK_EN
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    for (int i = 0; i < 4200; i++) frame_buf[i] = 8'(i);

    vecs[0] = '{512,  1'b0, -1, 512,  24'h200200, 5'b00000};
    vecs[1] = '{10,   1'b0, -1, 10,   24'h00A00A, 5'b00010};
    vecs[2] = '{1600, 1'b0, -1, 1518, 24'h640640, 5'b00100};
    vecs[3] = '{64,   1'b1, -1, 64,   24'h040040, 5'b00001};
    vecs[4] = '{63,   1'b0, -1, 63,   24'h03F03F, 5'b00010};
    vecs[5] = '{64,   1'b0, -1, 64,   24'h040040, 5'b00000};
    vecs[6] = '{0,    1'b0, -1, 0,    24'h000000, 5'b00010};
    vecs[7] = '{4100, 1'b0, -1, 1518, 24'hFFFFFF, 5'b00100};
    vecs[8] = '{10,   1'b1, 3,  10,   24'h00A00A, 5'b01011};

    bus.phy_data_in = 4'h0;
    bus.phy_rx_dv   = 1'b0;
    bus.phy_rx_er   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.r_data_valid}, 0);
    chk("rst_fend", {31'd0, bus.r_frame_end}, 0);
    chk("rst_ctrl", {8'd0, bus.r_ctrl_out}, 0);
    chk("rst_flags", {27'd0, bus.r_err_flags}, 0);
    rst_n = 1'b1;
    drive(4'h0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].nbytes, vecs[v].extra, vecs[v].er_byte);
      check_rec($sformatf("vec%0d", v), vecs[v].exp_strobes, vecs[v].exp_ctrl, vecs[v].exp_flags);
    end

    // Back-to-back: rx_er frame then a clean frame after a single idle cycle.
    send_frame(100, 1'b0, 50);
    send_frame(64, 1'b0, -1);
    check_rec("b2b_a", 100, 24'h064064, 5'b01000);
    check_rec("b2b_b", 64, 24'h040040, 5'b00000);

    // Bad preamble nibble: frame is dropped entirely.
    s0 = total_strobes;
    drive(4'h5, 1'b1, 1'b0);
    drive(4'h5, 1'b1, 1'b0);
    drive(4'h3, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(4'h7, 1'b1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    repeat (4) drive(4'h0, 1'b0, 1'b0);
    chk("drop_strobes", total_strobes - s0, 0);
    chk("drop_noend", recs.size(), 0);

    // Reset mid-frame, released while rx_dv is still high.
    for (int i = 0; i < 15; i++) drive(4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < 99; i++) begin
      drive(frame_buf[i][3:0], 1'b1, 1'b0);
      drive(frame_buf[i][7:4], 1'b1, 1'b0);
    end
    chk("pre_rst_valid", {31'd0, bus.r_data_valid}, 1);
    bus.phy_data_in = frame_buf[99][3:0];
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.r_data_valid}, 0);
    chk("async_rst_data", {24'd0, bus.r_data_out}, 0);
    drive(4'h5, 1'b1, 1'b0);
    drive(4'h5, 1'b1, 1'b0);
    rst_n = 1'b1;
    s0 = total_strobes;
    for (int i = 0; i < 5; i++) drive(4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(frame_buf[i][3:0], 1'b1, 1'b0);
      drive(frame_buf[i][7:4], 1'b1, 1'b0);
    end
    drive(4'h0, 1'b0, 1'b0);
    repeat (3) drive(4'h0, 1'b0, 1'b0);
    chk("disarm_strobes", total_strobes - s0, 0);
    chk("disarm_noend", recs.size(), 0);
    send_frame(64, 1'b0, -1);
    check_rec("post_rst", 64, 24'h040040, 5'b00000);

`ifdef RX_CRC_CHECK_EN
    begin
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 60; i++) c = crc_byte(c, frame_buf[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) frame_buf[60+k] = c[8*k +: 8];
      send_frame(64, 1'b0, -1);
      check_rec("crc_good", 64, 24'h040040, 5'b00000);
      frame_buf[5] = frame_buf[5] ^ 8'h01;
      send_frame(64, 1'b0, -1);
      check_rec("crc_bad", 64, 24'h040040, 5'b10000);
    end
`endif

    chk("no_coincide", coinc, 0);
    chk("no_stray_ends", recs.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phy_rx_deframer.md
Name: phy_rx_deframer

Overview:
- Receive-side counterpart of the transmit PHY path.
- Samples the 4-bit PHY nibble stream, hunts preamble/SFD, and packs nibbles (low nibble first) into bytes.
- Streams bytes out with a per-byte valid strobe.
- At end of frame, emits a one-cycle frame-end pulse with a 24-bit control word and error flags.
- Sits between the PHY receive pins and the receive buffer/queue logic.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (post-SFD); shorter frames flag runt.
- MAX_LEN, 1518, maximum bytes forwarded; excess bytes are counted but not emitted.

Ports:
- clk_phy  input  1  PHY clock; single clock domain.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- phy_data_in  input  4  receive nibble, low nibble of each byte first.
- phy_rx_dv  input  1  receive data valid.
- phy_rx_er  input  1  receive symbol error.
- r_data_out  output  8  assembled byte.
- r_data_valid  output  1  one-cycle strobe per assembled byte.
- r_frame_end  output  1  one-cycle pulse at end of frame.
- r_ctrl_out  output  24  {len[11:0], len[11:0]}; valid only with r_frame_end.
- r_err_flags  output  5  bit0 odd nibble, bit1 runt, bit2 too long, bit3 rx_er seen, bit4 FCS error.
- r_frame_err  output  1  OR of r_err_flags; valid with r_frame_end.

Behaviour:
- All outputs are registered; reset value 0.
- Reset asserts asynchronously and forces state IDLE.
- After reset release, the block is disarmed until phy_rx_dv is sampled 0 once. This prevents locking onto the middle of a frame.
- States:
  - IDLE (armed): rx_dv=1 and nibble==4'h5 -> PRE. rx_dv=1 with any other nibble -> DROP.
  - PRE: nibble 4'h5 -> stay. Nibble 4'hD -> DATA (phase=0, len=0, flags cleared). Other nibble -> DROP. rx_dv=0 -> IDLE, no outputs.
  - DATA, phase 0: latch low nibble; phase<=1.
  - DATA, phase 1: byte={nibble, low}. len<=len+1, saturating at 4095. If new len <= MAX_LEN, r_data_out<=byte and r_data_valid<=1 next cycle. Otherwise set bit2 and suppress output. phase<=0.
  - DATA: rx_er=1 on any rx_dv=1 cycle sets bit3. The nibble is still accepted.
  - DATA, rx_dv=0: next cycle r_frame_end=1 and r_ctrl_out={len,len}.
    - bit0 = (phase==1): the partial nibble is discarded, not counted.
    - bit1 = (len<MIN_LEN).
    - Then -> IDLE.
  - DROP: wait for rx_dv=0 -> IDLE. No outputs.
- Latency:
  - Byte valid: 1 cycle after its high nibble is sampled.
  - Frame end: 1 cycle after the first rx_dv=0 sample.
  - The last byte strobe and r_frame_end never coincide.
- Back-to-back frames: a single rx_dv=0 cycle between frames is sufficient. IDLE accepts a preamble nibble on the very next cycle.
- Empty frame (SFD then rx_dv=0): frame-end with len=0, bit1 set.
- len is 12 bits. A frame longer than 4095 bytes reports 4095 with bit2 set.
- Reset mid-frame: outputs are cleared immediately, with no frame-end pulse for the aborted frame.

Optional Feature:
- Macro RX_CRC_CHECK_EN.
- With the macro defined: a nibble-serial CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every DATA byte, including the trailing 4 FCS bytes.
  - At frame end, bit4 = (residue != 0xC704DD7B).
  - len and forwarded bytes include the FCS.
  - The CRC is reset on SFD.
- Without the macro: no CRC logic; bit4 is tied 0.

Test Plan:
1. 15 nibbles of 4'h5, then 4'hD, then 512 bytes of values 00..FF twice, then rx_dv=0 -> 512 strobes with matching data; r_frame_end with r_ctrl_out=24'h200200, r_err_flags=0.
2. Preamble/SFD + 10 bytes -> 10 strobes; ctrl 24'h00A00A, flags=5'b00010. Separately, 1600 bytes with MAX_LEN=1518 -> 1518 strobes; ctrl 24'h640640, bit2 set.
3. Preamble/SFD + 64 bytes + one extra nibble -> 64 strobes; ctrl 24'h040040, flags=5'b00001.
4. 100-byte frame with rx_er=1 on byte 50 -> 100 strobes, flags=5'b01000. Then a 1-cycle gap and a second 64-byte frame -> clean frame-end with flags=0.
5. reset=0 during byte 100 of a frame, released while rx_dv is still high with nibble 4'h5 -> no strobes until rx_dv falls. Next full 64-byte frame is received with ctrl 24'h040040.
6. (RX_CRC_CHECK_EN) 60-byte payload + correct FCS -> ctrl 24'h040040, flags=0. Same frame with one payload bit flipped -> flags=5'b10000.
